// File: rtl/alu_issue_stage.sv
// Issue stage for the 8-bit ALU: registers a request, waits opcode-dependent settle cycles, returns the result.
// Latency: response valid W edges after accept (W from op and opcode change); one transaction in flight.
// Backpressure: result held until rsp_ready; req_ready low outside IDLE. ALU_ISSUE_PARITY_EN adds rsp_par.
module alu_issue_stage #(
  parameter int ADD_WAIT  = 3,
  parameter int PASS_WAIT = 1,
  parameter int OPC_WAIT  = 1,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic [1:0] req_op,
  output logic [7:0] alu_i1,
  output logic [7:0] alu_i2,
  output logic [1:0] alu_opcode,
  input  logic [7:0] alu_o1,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       rsp_par
);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  localparam logic [CNT_W-1:0] ADD_W  = CNT_W'(ADD_WAIT);
  localparam logic [CNT_W-1:0] PASS_W = CNT_W'(PASS_WAIT);
  localparam logic [CNT_W-1:0] OPC_W  = CNT_W'(OPC_WAIT);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] wait_w;
  logic [1:0]       last_op;
  logic             err_pend;
  logic             accept;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // Illegal ops never touch the ALU, so they skip the opcode-change penalty.
  always_comb begin
    wait_w = (req_op == 2'b00) ? ADD_W : PASS_W;
    if (req_op != last_op)
      wait_w = wait_w + OPC_W;
    if (req_op == 2'b11)
      wait_w = ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_op    <= 2'b00;
      err_pend   <= 1'b0;
      alu_i1     <= 8'h00;
      alu_i2     <= 8'h00;
      alu_opcode <= 2'b00;
      rsp_valid  <= 1'b0;
      rsp_data   <= 8'h00;
      rsp_err    <= 1'b0;
`ifdef ALU_ISSUE_PARITY_EN
      rsp_par    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt      <= wait_w;
            err_pend <= (req_op == 2'b11);
            state    <= SETTLE;
            if (req_op != 2'b11) begin
              alu_i1     <= req_a;
              alu_i2     <= req_b;
              alu_opcode <= req_op;
              last_op    <= req_op;
            end
          end
        end
        SETTLE: begin
          cnt <= cnt - ONE;
          if (cnt == ONE) begin
            rsp_data  <= err_pend ? 8'h00 : alu_o1;
            rsp_err   <= err_pend;
            rsp_valid <= 1'b1;
`ifdef ALU_ISSUE_PARITY_EN
            rsp_par   <= !err_pend && (^alu_o1);
`endif
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef ALU_ISSUE_PARITY_EN
  assign rsp_par = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: randomized and directed requests against a reference model.
module tb_alu_issue_stage;

`ifdef ALU_ISSUE_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_a = 8'h00;
  logic [7:0] req_b = 8'h00;
  logic [1:0] req_op = 2'b00;
  logic [7:0] alu_i1, alu_i2, alu_o1;
  logic [1:0] alu_opcode;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_data;
  logic       rsp_err, rsp_par;

  alu_issue_stage dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_i1(alu_i1), .alu_i2(alu_i2), .alu_opcode(alu_opcode), .alu_o1(alu_o1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_par(rsp_par)
  );

  // Combinational ALU environment model
  always_comb begin
    case (alu_opcode)
      2'b00:   alu_o1 = alu_i1 + alu_i2;
      2'b01:   alu_o1 = alu_i1;
      2'b10:   alu_o1 = alu_i2;
      default: alu_o1 = 8'h00;
    endcase
  end

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       err;
    logic       par;
    int         acc;
    int         w;
  } exp_t;

  exp_t       q[$];
  exp_t       m_e;
  int         checks = 0;
  int         fails = 0;
  int         cyc = 0;
  logic [1:0] m_last = 2'b00;
  logic [7:0] e_i1 = 8'h00, e_i2 = 8'h00;
  logic [1:0] e_op = 2'b00;
  bit         bp_mode = 1'b0;
  bit         have_prev = 1'b0;
  int         prev_acc = 0, prev_w = 0;
  int         hold = 0;
  bit         prev_v = 1'b0;
  logic [7:0] h_d;
  logic       h_e, h_p;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_alu_i1"}, alu_i1, 0);
    chk({tag, "_alu_i2"}, alu_i2, 0);
    chk({tag, "_alu_opcode"}, alu_opcode, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_rsp_par"}, rsp_par, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
  endtask

  // Drive one request, compute its expected response from the opcode rules, return one cycle after accept.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    exp_t e;
    int   w;
    int   n = 0;
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
    #1;
    while (!req_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (!req_ready) begin
      checks++; fails++;
      $display("FAIL accept_timeout: req_ready stayed %0d, required 1", req_ready);
      return;
    end
    if (op == 2'b11) w = 1;
    else w = ((op == 2'b00) ? 3 : 1) + ((op != m_last) ? 1 : 0);
    case (op)
      2'b00:   e.data = a + b;
      2'b01:   e.data = a;
      2'b10:   e.data = b;
      default: e.data = 8'h00;
    endcase
    e.err = (op == 2'b11);
    e.par = PAR ? ^e.data : 1'b0;
    e.acc = cyc + 1;
    e.w   = w;
    if (have_prev)
      chk("throughput", e.acc - prev_acc, prev_w + 2 + (bp_mode ? 5 : 0));
    have_prev = 1'b1; prev_acc = e.acc; prev_w = w;
    q.push_back(e);
    if (op != 2'b11) m_last = op;
    @(posedge clk);
    if (op != 2'b11) begin e_i1 = a; e_i2 = b; e_op = op; end
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    req_valid = 1'b0;
    while (!(q.size() == 0 && req_ready && !rsp_valid) && n < 100) begin
      @(negedge clk); n++;
    end
    if (n >= 100) begin
      checks++; fails++;
      $display("FAIL idle_timeout: %0d responses outstanding, required 0", q.size());
    end
    have_prev = 1'b0;
  endtask

  task automatic mid_reset(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    wait_idle();
    issue(a, b, op);
    req_valid = 1'b0;
    #1 rst = 1'b1;
    q.delete();
    m_last = 2'b00; e_i1 = 8'h00; e_i2 = 8'h00; e_op = 2'b00; have_prev = 1'b0;
    #1 reset_checks("midrst");
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Response side: ready pattern generator
  always @(negedge clk) begin
    if (!bp_mode) rsp_ready = 1'b1;
    else if (rsp_valid) begin hold++; rsp_ready = (hold > 5); end
    else begin hold = 0; rsp_ready = 1'b0; end
  end

  // Monitor: pops the scoreboard when a response appears and checks it stays stable while held
  always @(negedge clk) begin
    if (rst) prev_v = 1'b0;
    else begin
      chk("alu_i1", alu_i1, e_i1);
      chk("alu_i2", alu_i2, e_i2);
      chk("alu_opcode", alu_opcode, e_op);
      if (rsp_valid) begin
        chk("req_ready_busy", req_ready, 0);
        if (!prev_v) begin
          if (q.size() == 0) chk("unexpected_rsp", q.size(), 1);
          else begin
            m_e = q.pop_front();
            chk("rsp_data", rsp_data, m_e.data);
            chk("rsp_err", rsp_err, m_e.err);
            chk("rsp_par", rsp_par, m_e.par);
            chk("latency", cyc - m_e.acc, m_e.w);
            h_d = m_e.data; h_e = m_e.err; h_p = m_e.par;
          end
        end else begin
          chk("hold_data", rsp_data, h_d);
          chk("hold_err", rsp_err, h_e);
          chk("hold_par", rsp_par, h_p);
        end
      end
      prev_v = rsp_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 reset_checks("reset");
    @(negedge clk) rst = 1'b0;
    @(negedge clk);

    issue(8'h12, 8'h34, 2'b00);
    issue(8'hA5, 8'h5A, 2'b01);
    issue(8'h3C, 8'h00, 2'b01);
    issue(8'hFF, 8'h00, 2'b11);
    issue(8'h81, 8'h00, 2'b01);
    issue(8'h07, 8'h09, 2'b10);
    wait_idle();

    bp_mode = 1'b1;
    issue(8'h11, 8'h22, 2'b00);
    issue(8'hF0, 8'h0F, 2'b01);
    issue(8'h00, 8'h00, 2'b11);
    wait_idle();
    bp_mode = 1'b0;

    mid_reset(8'h08, 8'h09, 2'b10);
    issue(8'h01, 8'h02, 2'b00);
    mid_reset(8'h12, 8'h34, 2'b00);
    issue(8'h05, 8'h06, 2'b00);
    wait_idle();

    for (int i = 0; i < 20; i++)
      issue(8'($urandom), 8'($urandom), 2'($urandom_range(0, 2)));
    wait_idle();
    for (int i = 0; i < 12; i++)
      issue(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));
    wait_idle();

    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Issue/capture stage directly upstream of the 8-bit ALU datapath.
- Accepts operand/opcode requests over a valid/ready handshake and registers them onto the ALU inputs (i1, i2, opcode[2:1]).
- Waits an opcode-dependent number of settle cycles covering the ALU path delays (add slowest; pass-through and opcode-change paths shorter), then captures the ALU output and returns it over a second valid/ready handshake.

Parameters:
ADD_WAIT, 3, settle cycles for opcode 2'b00 (add, i1,i2 *> o1 path)
PASS_WAIT, 1, settle cycles for opcodes 2'b01/2'b10 (pass-through i1/i2)
OPC_WAIT, 1, extra settle cycles added when the accepted opcode differs from the previous accepted opcode
CNT_W, 4, settle counter width; ADD_WAIT+OPC_WAIT must be <= 2**CNT_W-1

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  request valid
req_ready  out  1  request ready
req_a  in  8  operand A
req_b  in  8  operand B
req_op  in  2  opcode (00 add, 01 pass A, 10 pass B, 11 illegal)
alu_i1  out  8  registered operand to ALU i1
alu_i2  out  8  registered operand to ALU i2
alu_opcode  out  2  registered opcode to ALU opcode[2:1]
alu_o1  in  8  ALU result
rsp_valid  out  1  response valid
rsp_ready  in  1  response ready
rsp_data  out  8  captured result
rsp_err  out  1  response is for an illegal opcode
rsp_par  out  1  even parity of rsp_data (see Optional Feature)

Behaviour:
- Reset (async, rst=1): state IDLE; alu_i1, alu_i2, alu_opcode, rsp_data = 0; rsp_valid, rsp_err, rsp_par = 0; last_op = 2'b00; counter = 0. While rst=1, req_ready = 0.
- req_ready = (state==IDLE) && !rst, combinational. One transaction in flight; no overlap.
- FSM states: IDLE, SETTLE, HOLD.
- IDLE, on req_valid && req_ready (accept edge):
  - Legal op: load alu_i1=req_a, alu_i2=req_b, alu_opcode=req_op.
  - Counter W = (op==00 ? ADD_WAIT : PASS_WAIT) + (op!=last_op ? OPC_WAIT : 0).
  - last_op <= op; go to SETTLE.
  - Illegal op 11: ALU registers and last_op unchanged; counter W=1; error flag set; go to SETTLE.
- SETTLE: counter decrements each edge. On the edge where counter==1:
  - Legal op: rsp_data <= alu_o1, rsp_err <= 0.
  - Illegal op: rsp_data <= 0, rsp_err <= 1.
  - rsp_valid <= 1; go to HOLD.
- Latency: rsp_valid rises exactly W edges after the accept edge.
- HOLD: rsp_data/rsp_err/rsp_par held stable while rsp_valid=1 && !rsp_ready. On rsp_ready=1: rsp_valid <= 0, go to IDLE. req_ready reasserts the following cycle.
- alu_* outputs stay stable from the accept edge until the next accept edge, never changing mid-settle.
- rsp_ready asserted before rsp_valid: ignored.
- req_valid outside IDLE: ignored; requester must hold stimulus.
- Reset mid-operation: immediate abort to reset values; no response is generated for the in-flight request.

Optional Feature:
- Macro: ALU_ISSUE_PARITY_EN.
- Defined: rsp_par <= ^alu_o1 (XOR reduction), captured on the same edge as rsp_data. Illegal op gives rsp_par=0.
- Undefined: no parity logic; rsp_par tied 0.

Test Plan:
- Reset then add: req a=8'h12, b=8'h34, op=00, with last_op=00 → W=3. alu_i1=12, alu_i2=34 the cycle after accept; rsp_valid 3 edges after accept; rsp_data = model alu_o1 (8'h46); rsp_err=0.
- Opcode change: after add, req op=01, a=8'hA5 → W=PASS_WAIT+OPC_WAIT=2. rsp_data=8'hA5; with ALU_ISSUE_PARITY_EN, rsp_par=0. Repeating op=01 → W=1.
- Illegal op=11, a=8'hFF: ALU regs unchanged; rsp_valid after 1 edge; rsp_data=00, rsp_err=1; last_op unchanged, so next op=01 gives W=1.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid. Data, err and par stay stable; req_ready=0 throughout; accept occurs the cycle after rsp_ready=1.
- Reset mid-SETTLE (assert rst 1 cycle after accept of an add): all outputs 0 asynchronously; no rsp_valid afterwards; next request op=00 gives W=3 (last_op=00).
- Continuous req_valid with rsp_ready=1: throughput exactly one response per W+2 cycles; no dropped or duplicate responses over 20 random legal requests.
